// File: rtl/bp_be_pkg.sv
// Shared backend definitions: late-writeback requester indices and the
// integer writeback packet the parent assembles from the arbiter outputs.
package bp_be_pkg;

  localparam int late_num_req_lp = 3;

  typedef enum logic [1:0] {
    e_late_long  = 2'd0,
    e_late_dmiss = 2'd1,
    e_late_f2i   = 2'd2
  } bp_be_late_wb_src_e;

  typedef struct packed {
    logic        late;
    logic        ird_w_v;
    logic [4:0]  rd_addr;
    logic [63:0] data;
  } bp_be_wb_pkt_s;

endpackage

// File: rtl/bp_be_rr_pick.sv
// Rotating-priority picker: the search starts at ptr_i and wraps, and the
// first valid requester found wins.
module bp_be_rr_pick #(
  parameter int num_req_p = 3
) (
  input  logic [num_req_p-1:0]         v_i,
  input  logic [$clog2(num_req_p)-1:0] ptr_i,
  output logic [num_req_p-1:0]         grant_o,
  output logic [$clog2(num_req_p)-1:0] idx_o,
  output logic                         v_o
);

  localparam int idx_w_lp = $clog2(num_req_p);

  int idx;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    v_o     = 1'b0;
    idx     = 0;
    for (int j = 0; j < num_req_p; j++) begin
      idx = int'(ptr_i) + j;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (!v_o && v_i[idx]) begin
        v_o          = 1'b1;
        grant_o[idx] = 1'b1;
        idx_o        = idx_w_lp'(idx);
      end
    end
  end

endmodule

// File: rtl/bp_be_late_wb_arbiter.sv
// Shares the integer RF late-writeback port among long-latency producers,
// yielding to the early pipeline and stalling dispatch when they starve.
module bp_be_late_wb_arbiter
  import bp_be_pkg::*;
#(
  parameter int num_req_p        = late_num_req_lp,
  parameter int data_width_p     = 64,
  parameter int reg_addr_width_p = 5,
  parameter int starve_limit_p   = 4
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic [num_req_p-1:0]                  req_v_i,
  input  logic [num_req_p*reg_addr_width_p-1:0] req_rd_addr_i,
  input  logic [num_req_p*data_width_p-1:0]     req_data_i,
  output logic [num_req_p-1:0]                  req_ready_o,
  input  logic                                  early_wb_v_i,
  output logic                                  wb_v_o,
  output logic [reg_addr_width_p-1:0]           wb_rd_addr_o,
  output logic [data_width_p-1:0]               wb_data_o,
  output logic [$clog2(num_req_p)-1:0]          wb_src_o,
  output logic                                  stall_dispatch_o
);

  localparam int src_w_lp = $clog2(num_req_p);
  localparam int cnt_w_lp = $clog2(starve_limit_p + 1);
  localparam logic [cnt_w_lp-1:0] limit_lp = cnt_w_lp'(starve_limit_p);

  logic [num_req_p-1:0]        pick_grant;
  logic [src_w_lp-1:0]         pick_idx;
  logic                        pick_v;
  logic                        grant_en;
  logic                        any_grant;
  logic [reg_addr_width_p-1:0] sel_rd;
  logic [data_width_p-1:0]     sel_data;

  logic [src_w_lp-1:0]         ptr_q, ptr_d;
  logic [cnt_w_lp-1:0]         starve_cnt_q, starve_cnt_d;
  logic                        stall_q, stall_d;
  logic                        wb_v_q, wb_v_d;
  logic [reg_addr_width_p-1:0] wb_rd_q, wb_rd_d;
  logic [data_width_p-1:0]     wb_data_q, wb_data_d;
  logic [src_w_lp-1:0]         wb_src_q, wb_src_d;

  bp_be_rr_pick #(.num_req_p(num_req_p)) pick (
    .v_i     (req_v_i),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .v_o     (pick_v)
  );

  // Grants are suppressed while the early pipe owns the port and during reset.
  always_comb begin
    grant_en    = reset_n_i & ~early_wb_v_i;
    any_grant   = pick_v & grant_en;
    req_ready_o = pick_grant & {num_req_p{grant_en}};
    sel_rd      = req_rd_addr_i[int'(pick_idx)*reg_addr_width_p +: reg_addr_width_p];
    sel_data    = req_data_i[int'(pick_idx)*data_width_p +: data_width_p];
  end

  always_comb begin
    ptr_d        = ptr_q;
    wb_v_d       = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    wb_src_d     = wb_src_q;
    starve_cnt_d = starve_cnt_q;
    if (any_grant) begin
      ptr_d     = (pick_idx == src_w_lp'(num_req_p - 1)) ? '0 : pick_idx + 1'b1;
      wb_v_d    = |sel_rd;
      wb_rd_d   = sel_rd;
      wb_data_d = sel_data;
      wb_src_d  = pick_idx;
    end
    if (any_grant || !(|req_v_i)) begin
      starve_cnt_d = '0;
    end else if (early_wb_v_i && (starve_cnt_q != limit_lp)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
    stall_d = (starve_cnt_d == limit_lp);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_q        <= '0;
      starve_cnt_q <= '0;
      stall_q      <= 1'b0;
      wb_v_q       <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      wb_src_q     <= '0;
    end else begin
      ptr_q        <= ptr_d;
      starve_cnt_q <= starve_cnt_d;
      stall_q      <= stall_d;
      wb_v_q       <= wb_v_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      wb_src_q     <= wb_src_d;
    end
  end

  assign wb_v_o           = wb_v_q;
  assign wb_rd_addr_o     = wb_rd_q;
  assign wb_data_o        = wb_data_q;
  assign wb_src_o         = wb_src_q;
  assign stall_dispatch_o = stall_q;

endmodule

// File: tb/tb_bp_be_late_wb_arbiter.sv
// Directed bench for the late writeback arbiter with hand-computed expectations.
module tb_bp_be_late_wb_arbiter;
  import bp_be_pkg::*;

  logic         clk_i;
  logic         reset_n_i;
  logic [2:0]   req_v_i;
  logic [14:0]  req_rd_addr_i;
  logic [191:0] req_data_i;
  logic [2:0]   req_ready_o;
  logic         early_wb_v_i;
  logic         wb_v_o;
  logic [4:0]   wb_rd_addr_o;
  logic [63:0]  wb_data_o;
  logic [1:0]   wb_src_o;
  logic         stall_dispatch_o;

  int total;
  int bad;

  bp_be_late_wb_arbiter dut (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .req_v_i          (req_v_i),
    .req_rd_addr_i    (req_rd_addr_i),
    .req_data_i       (req_data_i),
    .req_ready_o      (req_ready_o),
    .early_wb_v_i     (early_wb_v_i),
    .wb_v_o           (wb_v_o),
    .wb_rd_addr_o     (wb_rd_addr_o),
    .wb_data_o        (wb_data_o),
    .wb_src_o         (wb_src_o),
    .stall_dispatch_o (stall_dispatch_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic setReq(input int i, input logic [4:0] rd, input logic [63:0] data);
    req_rd_addr_i[i*5 +: 5] = rd;
    req_data_i[i*64 +: 64]  = data;
  endtask

  // Drive on the falling edge and settle so combinational grants can be sampled.
  task automatic applyStimulus(input logic [2:0] v, input logic early);
    @(negedge clk_i);
    req_v_i      = v;
    early_wb_v_i = early;
    #1;
  endtask

  task automatic stepEdge();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkWb(input string tag, input logic v, input logic [4:0] rd,
                         input logic [63:0] data, input logic [1:0] src);
    checkOutput({tag, ".wb_v"}, 64'(wb_v_o), 64'(v));
    checkOutput({tag, ".rd"}, 64'(wb_rd_addr_o), 64'(rd));
    checkOutput({tag, ".data"}, wb_data_o, data);
    checkOutput({tag, ".src"}, 64'(wb_src_o), 64'(src));
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    req_v_i       = 3'b111;
    req_rd_addr_i = '0;
    req_data_i    = '0;
    early_wb_v_i  = 1'b0;
    reset_n_i     = 1'b1;
    #2 reset_n_i  = 1'b0;
    #1;
    checkOutput("rst.ready", 64'(req_ready_o), 64'b000);
    checkWb("rst", 1'b0, 5'd0, 64'h0, 2'd0);
    checkOutput("rst.stall", 64'(stall_dispatch_o), 64'd0);

    applyStimulus(3'b000, 1'b0);
    reset_n_i = 1'b1;
    for (int c = 0; c < 10; c++) stepEdge();
    checkOutput("idle.ready", 64'(req_ready_o), 64'b000);
    checkWb("idle", 1'b0, 5'd0, 64'h0, 2'd0);
    checkOutput("idle.stall", 64'(stall_dispatch_o), 64'd0);

    setReq(int'(e_late_long), 5'd5, 64'hA);
    setReq(int'(e_late_dmiss), 5'd6, 64'hB);
    setReq(int'(e_late_f2i), 5'd7, 64'hC);
    applyStimulus(3'b111, 1'b0);
    checkOutput("rr0.ready", 64'(req_ready_o), 64'b001);
    stepEdge();
    checkWb("rr0", 1'b1, 5'd5, 64'hA, 2'd0);
    applyStimulus(3'b111, 1'b0);
    checkOutput("rr1.ready", 64'(req_ready_o), 64'b010);
    stepEdge();
    checkWb("rr1", 1'b1, 5'd6, 64'hB, 2'd1);
    applyStimulus(3'b111, 1'b0);
    checkOutput("rr2.ready", 64'(req_ready_o), 64'b100);
    stepEdge();
    checkWb("rr2", 1'b1, 5'd7, 64'hC, 2'd2);
    applyStimulus(3'b000, 1'b0);
    checkOutput("hold.ready", 64'(req_ready_o), 64'b000);
    stepEdge();
    checkWb("hold", 1'b0, 5'd7, 64'hC, 2'd2);

    // Starvation: requester 1 blocked by the early pipe for six cycles.
    for (int c = 1; c <= 6; c++) begin
      applyStimulus(3'b010, 1'b1);
      checkOutput($sformatf("starve%0d.ready", c), 64'(req_ready_o), 64'b000);
      stepEdge();
      checkOutput($sformatf("starve%0d.wb_v", c), 64'(wb_v_o), 64'd0);
      checkOutput($sformatf("starve%0d.stall", c), 64'(stall_dispatch_o), (c >= 4) ? 64'd1 : 64'd0);
    end
    applyStimulus(3'b010, 1'b0);
    checkOutput("unstarve.ready", 64'(req_ready_o), 64'b010);
    checkOutput("unstarve.stall_held", 64'(stall_dispatch_o), 64'd1);
    stepEdge();
    checkWb("unstarve", 1'b1, 5'd6, 64'hB, 2'd1);
    checkOutput("unstarve.stall", 64'(stall_dispatch_o), 64'd0);

    setReq(0, 5'd1, 64'h11);
    setReq(2, 5'd3, 64'h33);
    applyStimulus(3'b101, 1'b0);
    checkOutput("wrap0.ready", 64'(req_ready_o), 64'b100);
    stepEdge();
    checkWb("wrap0", 1'b1, 5'd3, 64'h33, 2'd2);
    applyStimulus(3'b001, 1'b0);
    checkOutput("wrap1.ready", 64'(req_ready_o), 64'b001);
    stepEdge();
    checkWb("wrap1", 1'b1, 5'd1, 64'h11, 2'd0);

    setReq(1, 5'd0, 64'hFF);
    applyStimulus(3'b010, 1'b0);
    checkOutput("x0.ready", 64'(req_ready_o), 64'b010);
    stepEdge();
    checkWb("x0", 1'b0, 5'd0, 64'hFF, 2'd1);
    setReq(0, 5'd5, 64'hA);
    setReq(1, 5'd6, 64'hB);
    setReq(2, 5'd7, 64'hC);
    applyStimulus(3'b111, 1'b0);
    checkOutput("x0adv.ready", 64'(req_ready_o), 64'b100);
    stepEdge();
    checkWb("x0adv", 1'b1, 5'd7, 64'hC, 2'd2);

    // Advance the pointer to 1, then reset in the middle of a grant cycle.
    applyStimulus(3'b111, 1'b0);
    stepEdge();
    checkWb("pre", 1'b1, 5'd5, 64'hA, 2'd0);
    applyStimulus(3'b111, 1'b0);
    checkOutput("mid.ready", 64'(req_ready_o), 64'b010);
    reset_n_i = 1'b0;
    #1;
    checkOutput("midrst.ready", 64'(req_ready_o), 64'b000);
    checkWb("midrst", 1'b0, 5'd0, 64'h0, 2'd0);
    checkOutput("midrst.stall", 64'(stall_dispatch_o), 64'd0);
    stepEdge();
    checkOutput("midrst.nopulse", 64'(wb_v_o), 64'd0);
    applyStimulus(3'b111, 1'b0);
    reset_n_i = 1'b1;
    #1;
    checkOutput("post.ready", 64'(req_ready_o), 64'b001);
    stepEdge();
    checkWb("post", 1'b1, 5'd5, 64'hA, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
